// File: rtl/lsc_pkg.sv
// lsc_pkg: shared widths, arbiter state encoding and helpers for the LSC port arbiter.
// Rev 1.0
`default_nettype none

package lsc_pkg;

  localparam int LSC_HADDR_W = 40;
  localparam int LSC_LADDR_W = 12;
  localparam int LSC_LEN_W   = 16;
  localparam int LSC_DATA_W  = 128;

  typedef logic [1:0] arb_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  function automatic logic [LSC_LEN_W-1:0] sat_inc(input logic [LSC_LEN_W-1:0] v);
    return (v == {LSC_LEN_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsc_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set request at or after ptr (wrapping).
// Rev 1.0
`default_nettype none

module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int j;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
        valid  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lsc_arbiter.sv
// lsc_arbiter: round-robin arbiter sharing one loadStoreController core port among N cores.
// Rev 1.0
`default_nettype none

module lsc_arbiter
  import lsc_pkg::*;
#(
  parameter int N       = 4,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             core_req,
  input  logic [N-1:0]             core_rwn,
  input  logic [N*LSC_HADDR_W-1:0] core_hostAddr,
  input  logic [N*LSC_LADDR_W-1:0] core_localAddr,
  input  logic [N*LSC_LEN_W-1:0]   core_transferLength,
  input  logic [N*LSC_DATA_W-1:0]  core_writeData,
  output logic [N-1:0]             core_ready,
  output logic [N-1:0]             core_ack,
  output logic [LSC_DATA_W-1:0]    core_readData,
  output logic [N-1:0]             core_gnt,
  output logic                     lsc_req,
  output logic                     lsc_rwn,
  output logic [LSC_HADDR_W-1:0]   lsc_hostAddr,
  output logic [LSC_LADDR_W-1:0]   lsc_localAddr,
  output logic [LSC_LEN_W-1:0]     lsc_transferLength,
  output logic [LSC_DATA_W-1:0]    lsc_writeData,
  input  logic                     lsc_ready,
  input  logic                     lsc_ack,
  input  logic [LSC_DATA_W-1:0]    lsc_readData,
  output logic [LSC_LEN_W-1:0]     beat_cnt,
  output logic                     err_timeout
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  arb_state_t       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [N-1:0]     gnt;
  logic [LSC_LEN_W-1:0] beats;
  logic [TMR_W-1:0] timer;
  logic [GAP_W-1:0] gap_cnt;
  logic             err;

  logic [N-1:0]     pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             owner_req;
  logic             timeout_hit;
  logic             gap_done;
  logic [IDX_W-1:0] next_ptr;
  int               own_i;

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (core_req),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign own_i       = int'(owner);
  assign owner_req   = core_req[owner];
  assign timeout_hit = (TIMEOUT != 0) && (timer == TMR_W'(TIMEOUT - 1));
  assign gap_done    = (gap_cnt == GAP_W'(GAP));
  assign next_ptr    = (owner == IDX_W'(N - 1)) ? '0 : owner + 1'b1;

  assign lsc_req       = owner_req && (state == ST_GRANT || state == ST_BUSY);
  assign core_ready    = lsc_ready ? gnt : '0;
  assign core_ack      = lsc_ack ? gnt : '0;
  assign core_readData = lsc_readData;
  assign core_gnt      = gnt;
  assign beat_cnt      = beats;
  assign err_timeout   = err;

  // Fields are forced to zero while no core owns the port.
  always_comb begin
    lsc_rwn            = 1'b0;
    lsc_hostAddr       = '0;
    lsc_localAddr      = '0;
    lsc_transferLength = '0;
    lsc_writeData      = '0;
    if (|gnt) begin
      lsc_rwn            = core_rwn[owner];
      lsc_hostAddr       = core_hostAddr[own_i*LSC_HADDR_W +: LSC_HADDR_W];
      lsc_localAddr      = core_localAddr[own_i*LSC_LADDR_W +: LSC_LADDR_W];
      lsc_transferLength = core_transferLength[own_i*LSC_LEN_W +: LSC_LEN_W];
      lsc_writeData      = core_writeData[own_i*LSC_DATA_W +: LSC_DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      gnt     <= '0;
      beats   <= '0;
      timer   <= '0;
      gap_cnt <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner <= pick_idx;
            gnt   <= pick_gnt;
            beats <= '0;
            timer <= '0;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (lsc_ready) begin
            state <= ST_BUSY;
          end else if (!owner_req) begin
            state <= ST_DRAIN;
          end else if (timeout_hit) begin
            err   <= 1'b1;
            state <= ST_DRAIN;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_BUSY: begin
          if (lsc_ack) begin
            beats <= sat_inc(beats);
          end
          if (!lsc_ready) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Once the gap count has started it runs to completion regardless of req.
          if (gap_cnt != '0 || (!owner_req && !lsc_ready)) begin
            if (gap_done) begin
              gnt     <= '0;
              rr_ptr  <= next_ptr;
              gap_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
